// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate/target generator: operation encodings
// and the default datapath widths that decode also uses.
package imm_extend_pipe_pkg;

    localparam int IMM_W = 17;
    localparam int XLEN  = 32;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'b00,
        EXT_ZERO  = 2'b01,
        EXT_PCREL = 2'b10,
        EXT_UPPER = 2'b11
    } ext_mode_e;

    // Top two bits of the widened PC sum: any set bit means the exact target
    // fell below zero or reached 2^OUT_W.
    function automatic logic pcrel_wrapped(input logic [1:0] sum_top);
        return |sum_top;
    endfunction

endpackage

// File: rtl/imm_extend_pipe_ext_core.sv
// Combinational immediate widener. PCREL yields the sign-extended offset; the
// PC add happens one stage later.
module ext_core
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = XLEN
) (
    input  logic [IN_W-1:0]  imm,
    input  ext_mode_e        mode,
    output logic [OUT_W-1:0] ext
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sign_val;
    logic [OUT_W-1:0] zero_val;
    logic [OUT_W-1:0] upper_val;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_bit
            if (gi < IN_W) begin : g_low
                assign sign_val[gi] = imm[gi];
                assign zero_val[gi] = imm[gi];
            end else begin : g_high
                assign sign_val[gi] = imm[IN_W-1];
                assign zero_val[gi] = 1'b0;
            end

            // Upper mode places the immediate flush against the MSB.
            if (gi < PAD_W) begin : g_upper_pad
                assign upper_val[gi] = 1'b0;
            end else begin : g_upper_imm
                assign upper_val[gi] = imm[gi-PAD_W];
            end
        end
    endgenerate

    always_comb begin
        ext = sign_val;
        case (mode)
            EXT_SIGN:  ext = sign_val;
            EXT_ZERO:  ext = zero_val;
            EXT_PCREL: ext = sign_val;
            EXT_UPPER: ext = upper_val;
            default:   ext = sign_val;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate/target generator with valid/ready flow control.
// Stage 1 widens the immediate; stage 2 adds the PC for PC-relative targets.
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = XLEN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [OUT_W-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int SUM_W = OUT_W + 2;

    logic             s1_valid_reg, s1_valid_next;
    logic [OUT_W-1:0] s1_ext_reg,   s1_ext_next;
    ext_mode_e        s1_mode_reg,  s1_mode_next;
    logic [OUT_W-1:0] s1_pc_reg,    s1_pc_next;

    logic             s2_valid_reg, s2_valid_next;
    logic [OUT_W-1:0] s2_data_reg,  s2_data_next;
    logic             s2_ovf_reg,   s2_ovf_next;

    logic             adv1;
    logic             adv2;
    logic [OUT_W-1:0] ext_val;
    logic [SUM_W-1:0] pc_wide;
    logic [SUM_W-1:0] off_wide;
    logic [SUM_W-1:0] target_sum;
    logic [OUT_W-1:0] s2_result;
    logic             s2_result_ovf;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext_core (
        .imm  (in_imm),
        .mode (ext_mode_e'(in_mode)),
        .ext  (ext_val)
    );

    assign adv2     = !s2_valid_reg || out_ready;
    assign adv1     = !s1_valid_reg || adv2;
    assign in_ready = adv1 && !reset;

    // Exact PC + 1 + offset; two guard bits expose both underflow and carry-out.
    assign pc_wide    = {2'b00, s1_pc_reg};
    assign off_wide   = {{2{s1_ext_reg[OUT_W-1]}}, s1_ext_reg};
    assign target_sum = pc_wide + off_wide + SUM_W'(1);

    always_comb begin
        s2_result     = s1_ext_reg;
        s2_result_ovf = 1'b0;
        if (s1_mode_reg == EXT_PCREL) begin
            s2_result     = target_sum[OUT_W-1:0];
            s2_result_ovf = pcrel_wrapped(target_sum[SUM_W-1:OUT_W]);
        end
    end

    always_comb begin
        s1_valid_next = s1_valid_reg;
        s1_ext_next   = s1_ext_reg;
        s1_mode_next  = s1_mode_reg;
        s1_pc_next    = s1_pc_reg;
        s2_valid_next = s2_valid_reg;
        s2_data_next  = s2_data_reg;
        s2_ovf_next   = s2_ovf_reg;

        if (adv1) begin
            s1_valid_next = in_valid;
            if (in_valid) begin
                s1_ext_next  = ext_val;
                s1_mode_next = ext_mode_e'(in_mode);
                s1_pc_next   = in_pc;
            end
        end

        // Output data only changes when a real item lands, so it holds across bubbles.
        if (adv2) begin
            s2_valid_next = s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_next = s2_result;
                s2_ovf_next  = s2_result_ovf;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_ovf_reg   <= 1'b0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s2_valid_reg <= s2_valid_next;
            s2_data_reg  <= s2_data_next;
            s2_ovf_reg   <= s2_ovf_next;
        end
    end

    always_ff @(posedge clock) begin
        s1_ext_reg  <= s1_ext_next;
        s1_mode_reg <= s1_mode_next;
        s1_pc_reg   <= s1_pc_next;
    end

    assign out_valid = s2_valid_reg;
    assign out_data  = s2_data_reg;
    assign out_ovf   = s2_ovf_reg;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: the driver queues hand-computed results
// on acceptance, a negedge monitor pops and compares on every consumed output.
module tb_imm_extend_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        o;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [16:0] in_imm;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;

    logic [31:0] exp_d;
    logic        exp_o;
    exp_t        sb[$];
    int          rx_cyc[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rx_count = 0;

    always #5 clock = ~clock;

    imm_extend_pipe #(.IN_W(17), .OUT_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_imm    (in_imm),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, req);
        end
    endtask

    // Accepted items enter the scoreboard; reset discards everything in flight.
    always @(posedge clock) begin
        cyc++;
        if (reset)
            sb.delete();
        else if (in_valid && in_ready)
            sb.push_back('{d: exp_d, o: exp_o});
    end

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got data=%h ovf=%b want none", out_data, out_ovf);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.d || out_ovf !== e.o) begin
                    bad++;
                    $display("FAIL sb_result: got data=%h ovf=%b want data=%h ovf=%b",
                             out_data, out_ovf, e.d, e.o);
                end
                $display("rx #%0d cyc=%0d data=%h ovf=%b", rx_count, cyc, out_data, out_ovf);
            end
            rx_count++;
            rx_cyc.push_back(cyc);
        end
    end

    task automatic send(input logic [1:0] m, input logic [16:0] imm, input logic [31:0] pc,
                        input logic [31:0] d, input logic o, output int waits);
        logic acc;
        acc      = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_imm   = imm;
        in_pc    = pc;
        exp_d    = d;
        exp_o    = o;
        for (int t = 0; t < 40; t++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            if (acc) break;
            waits++;
        end
        check("send_accept", {31'd0, acc}, 32'd1);
        $display("tx mode=%b imm=%h pc=%h exp=%h/%b waits=%0d", m, imm, pc, d, o, waits);
        in_valid = 1'b0;
        in_imm   = 17'h15A5A;
        in_pc    = 32'hDEADBEEF;
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            @(posedge clock);
            #1;
            if (sb.size() == 0) break;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int w;
        int r0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_mode   = 2'b00;
        in_imm    = '0;
        in_pc     = '0;
        exp_d     = '0;
        exp_o     = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single SIGN item: valid must appear exactly two cycles after the accept cycle.
        out_ready = 1'b1;
        send(2'b00, 17'h10000, 32'h0, 32'hFFFF0000, 1'b0, w);
        check("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clock);
        #1;
        check("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
        drain();

        send(2'b01, 17'h10000, 32'h0,        32'h00010000, 1'b0, w);
        send(2'b11, 17'h00001, 32'h0,        32'h00008000, 1'b0, w);
        send(2'b10, 17'h1FFFE, 32'h00000010, 32'h0000000F, 1'b0, w);
        send(2'b10, 17'h00000, 32'hFFFFFFFF, 32'h00000000, 1'b1, w);
        send(2'b10, 17'h1FFFE, 32'h00000000, 32'hFFFFFFFF, 1'b1, w);
        send(2'b10, 17'h0FFFF, 32'h7FFF0000, 32'h80000000, 1'b0, w);
        drain();

        // Stall: consumer blocks for three cycles starting at the first valid output.
        out_ready = 1'b0;
        r0 = rx_count;
        fork
            begin
                int sw;
                for (int i = 1; i <= 4; i++)
                    send(2'b00, 17'(i), 32'h0, 32'(i), 1'b0, sw);
            end
            begin
                for (int t = 0; t < 20; t++) begin
                    @(negedge clock);
                    if (out_valid) break;
                end
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clock);
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_data", out_data, 32'h00000001);
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                end
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_rx_count", rx_count - r0, 4);

        // Sustained throughput: one accept and one result every cycle.
        rx_cyc.delete();
        r0 = rx_count;
        for (int i = 0; i < 10; i++) begin
            send(2'b01, 17'h00100 + 17'(i), 32'h0, 32'h00000100 + 32'(i), 1'b0, w);
            check("tput_no_wait", w, 0);
        end
        drain();
        check("tput_rx_count", rx_count - r0, 10);
        check("tput_span", (rx_cyc.size() == 10) ? (rx_cyc[9] - rx_cyc[0]) : -1, 9);

        // Reset with two items in flight: both must vanish.
        out_ready = 1'b0;
        send(2'b10, 17'h00004, 32'h00001000, 32'h00001005, 1'b0, w);
        send(2'b00, 17'h00007, 32'h0,        32'h00000007, 1'b0, w);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_out_data", out_data, 32'd0);
        check("flush_out_ovf", {31'd0, out_ovf}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        r0 = rx_count;
        out_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("flush_no_output", rx_count - r0, 0);

        send(2'b00, 17'h0FFFF, 32'h0, 32'h0000FFFF, 1'b0, w);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
